// File: rtl/tpu_cmd_pkg.sv
// Shared command format and sequencer state encoding for the TPU host command path.
package tpu_cmd_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned LEN_W          = 8;
    localparam int unsigned CMD_W          = 64;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr_d;
        logic [DEF_ADDR_WIDTH-1:0] addr_c;
        logic [DEF_ADDR_WIDTH-1:0] addr_b;
        logic [DEF_ADDR_WIDTH-1:0] addr_a;
        logic [LEN_W-1:0]          len_n;
        logic [LEN_W-1:0]          len_k;
        logic [LEN_W-1:0]          len_m;
    } command_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    // Each address field advances independently and wraps at its own width.
    function automatic command_t advance_cmd(command_t c, logic [DEF_ADDR_WIDTH-1:0] stride);
        command_t r;
        r        = c;
        r.addr_a = c.addr_a + stride;
        r.addr_b = c.addr_b + stride;
        r.addr_c = c.addr_c + stride;
        r.addr_d = c.addr_d + stride;
        return r;
    endfunction

endpackage

// File: rtl/tpu_cmd_sequencer_if.sv
// Host descriptor port plus control_unit command/done port of the command sequencer.
interface tpu_cmd_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = tpu_cmd_pkg::DEF_ADDR_WIDTH,
    parameter int unsigned BATCH_W    = 8
);
    import tpu_cmd_pkg::*;

    logic                  host_desc_valid;
    logic                  host_desc_ready;
    command_t              host_desc_cmd;
    logic [BATCH_W-1:0]    host_desc_batch;
    logic [ADDR_WIDTH-1:0] host_desc_stride;
    logic                  cmd_valid;
    logic                  cmd_ready;
    command_t              cmd_data;
    logic                  cu_done;

    // master: the sequencer; slave: host plus control_unit environment.
    modport master (
        input  host_desc_valid, host_desc_cmd, host_desc_batch, host_desc_stride,
        input  cmd_ready, cu_done,
        output host_desc_ready, cmd_valid, cmd_data
    );

    modport slave (
        output host_desc_valid, host_desc_cmd, host_desc_batch, host_desc_stride,
        output cmd_ready, cu_done,
        input  host_desc_ready, cmd_valid, cmd_data
    );

endinterface

// File: rtl/tpu_cmd_sequencer_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible on rdata whenever not empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tpu_cmd_sequencer.sv
// Queues host descriptors and expands each into a strided batch of control_unit
// commands, issuing one command at a time and waiting for cu_done between them.
module tpu_cmd_sequencer
    import tpu_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned BATCH_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    tpu_cmd_sequencer_if.master    bus,
    output logic [$clog2(DEPTH):0] queue_level,
    output logic                   seq_busy,
    output logic                   desc_done,
    output logic                   err_batch_zero,
    output logic                   err_stray_done
);

    localparam int unsigned ENTRY_W = CMD_W + BATCH_W + ADDR_WIDTH;

    logic [ENTRY_W-1:0]    fifo_wdata;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  desc_accept;
    command_t              head_cmd;
    logic [BATCH_W-1:0]    head_batch;
    logic [ADDR_WIDTH-1:0] head_stride;

    state_e                state_q,      state_d;
    command_t              cur_cmd_q,    cur_cmd_d;
    logic [BATCH_W-1:0]    remaining_q,  remaining_d;
    logic [ADDR_WIDTH-1:0] stride_q,     stride_d;
    logic                  cmd_valid_q,  cmd_valid_d;
    logic                  desc_done_q,  desc_done_d;
    logic                  err_bz_q,     err_bz_d;
    logic                  err_sd_q,     err_sd_d;

    // Zero-length descriptors are consumed from the host but never stored.
    assign desc_accept = bus.host_desc_valid && bus.host_desc_ready;
    assign fifo_push   = desc_accept && (bus.host_desc_batch != '0);
    assign fifo_wdata  = {bus.host_desc_cmd, bus.host_desc_batch, bus.host_desc_stride};
    assign {head_cmd, head_batch, head_stride} = fifo_rdata;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_desc_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (queue_level)
    );

    assign bus.host_desc_ready = !fifo_full;
    assign bus.cmd_valid       = cmd_valid_q;
    assign bus.cmd_data        = cur_cmd_q;
    assign seq_busy            = (state_q != ST_IDLE) || !fifo_empty;
    assign desc_done           = desc_done_q;
    assign err_batch_zero      = err_bz_q;
    assign err_stray_done      = err_sd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_cmd_q   <= '0;
            remaining_q <= '0;
            stride_q    <= '0;
            cmd_valid_q <= 1'b0;
            desc_done_q <= 1'b0;
            err_bz_q    <= 1'b0;
            err_sd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_cmd_q   <= cur_cmd_d;
            remaining_q <= remaining_d;
            stride_q    <= stride_d;
            cmd_valid_q <= cmd_valid_d;
            desc_done_q <= desc_done_d;
            err_bz_q    <= err_bz_d;
            err_sd_q    <= err_sd_d;
        end
    end

    // cmd_valid is registered from the ISSUE state, so it rises one edge after entry.
    always_comb begin
        state_d     = state_q;
        cur_cmd_d   = cur_cmd_q;
        remaining_d = remaining_q;
        stride_d    = stride_q;
        cmd_valid_d = 1'b0;
        desc_done_d = 1'b0;
        err_bz_d    = desc_accept && (bus.host_desc_batch == '0);
        err_sd_d    = bus.cu_done;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    cur_cmd_d   = head_cmd;
                    remaining_d = head_batch;
                    stride_d    = head_stride;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_valid_q && bus.cmd_ready) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cmd_valid_d = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                err_sd_d = 1'b0;
                if (bus.cu_done) begin
                    if (remaining_q > BATCH_W'(1)) begin
                        cur_cmd_d   = advance_cmd(cur_cmd_q, DEF_ADDR_WIDTH'(stride_q));
                        remaining_d = remaining_q - BATCH_W'(1);
                        state_d     = ST_ISSUE;
                    end else begin
                        desc_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tpu_cmd_sequencer.sv
// Scoreboard bench for tpu_cmd_sequencer: directed descriptors, expected commands queued.
module tb_tpu_cmd_sequencer;
    import tpu_cmd_pkg::*;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BW    = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [$clog2(DEPTH):0] queue_level;
    logic                   seq_busy;
    logic                   desc_done;
    logic                   err_batch_zero;
    logic                   err_stray_done;

    tpu_cmd_sequencer_if #(.ADDR_WIDTH(AW), .BATCH_W(BW)) bus ();

    tpu_cmd_sequencer #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .BATCH_W    (BW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .queue_level    (queue_level),
        .seq_busy       (seq_busy),
        .desc_done      (desc_done),
        .err_batch_zero (err_batch_zero),
        .err_stray_done (err_stray_done)
    );

    always #5 clk = ~clk;

    command_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int served   = 0;
    int dd_cnt   = 0;
    int ebz_cnt  = 0;
    int esd_cnt  = 0;
    bit outstanding = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic command_t mk(input int a, input int b, input int c, input int d,
                                    input int k, input int n, input int m);
        command_t r;
        r.addr_a = AW'(a);
        r.addr_b = AW'(b);
        r.addr_c = AW'(c);
        r.addr_d = AW'(d);
        r.len_k  = 8'(k);
        r.len_n  = 8'(n);
        r.len_m  = 8'(m);
        return r;
    endfunction

    // Monitor: every command handshake is checked against the scoreboard head.
    always @(negedge clk) begin
        command_t e;
        if (rst) begin
            outstanding = 1'b0;
        end else begin
            if (bus.cu_done) outstanding = 1'b0;
            if (bus.cmd_valid && bus.cmd_ready) begin
                check("cmd_overlap", 64'(outstanding), 64'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cmd_unexpected: got 0x%0h, required no command", bus.cmd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_data", 64'(bus.cmd_data), 64'(e));
                end
                hs_cnt++;
                outstanding = 1'b1;
            end
            if (desc_done)      dd_cnt++;
            if (err_batch_zero) ebz_cnt++;
            if (err_stray_done) esd_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input command_t c, input int batch, input int stride, output bit acc);
        bus.host_desc_valid  = 1'b1;
        bus.host_desc_cmd    = c;
        bus.host_desc_batch  = BW'(batch);
        bus.host_desc_stride = AW'(stride);
        acc = bus.host_desc_ready;
        tick();
        bus.host_desc_valid = 1'b0;
    endtask

    task automatic push(input command_t c, input int batch, input int stride);
        int t;
        bit acc;
        t = 0;
        while (!bus.host_desc_ready && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: host_desc_ready stuck at 0, required 1");
        end
        offer(c, batch, stride, acc);
    endtask

    task automatic wait_hs();
        int t;
        t = 0;
        while (hs_cnt <= served && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL hs_timeout: handshakes %0d, required %0d", hs_cnt, served + 1);
        end else begin
            served++;
        end
    endtask

    task automatic pulse_done();
        bus.cu_done = 1'b1;
        tick();
        bus.cu_done = 1'b0;
    endtask

    task automatic serve(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            wait_hs();
            repeat (gap) tick();
            pulse_done();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int hs0;
        rst                  = 1'b1;
        bus.host_desc_valid  = 1'b0;
        bus.host_desc_cmd    = '0;
        bus.host_desc_batch  = '0;
        bus.host_desc_stride = '0;
        bus.cmd_ready        = 1'b1;
        bus.cu_done          = 1'b0;
        repeat (3) tick();
        check("rst_ready",     64'(bus.host_desc_ready), 64'd1);
        check("rst_cmd_valid", 64'(bus.cmd_valid),       64'd0);
        check("rst_level",     64'(queue_level),         64'd0);
        check("rst_busy",      64'(seq_busy),            64'd0);
        check("rst_pulses",    64'({desc_done, err_batch_zero, err_stray_done}), 64'd0);
        rst = 1'b0;
        tick();

        // Single command, latency and desc_done timing
        exp_q.push_back(mk(12'h100, 12'h200, 12'h300, 12'h400, 8, 8, 16));
        push(mk(12'h100, 12'h200, 12'h300, 12'h400, 8, 8, 16), 1, 0);
        check("lat_t0", 64'(bus.cmd_valid), 64'd0);
        tick();
        check("lat_t1", 64'(bus.cmd_valid), 64'd0);
        tick();
        check("lat_t2", 64'(bus.cmd_valid), 64'd1);
        serve(1, 2);
        check("desc_done_pulse", 64'(desc_done), 64'd1);
        tick();
        check("desc_done_end",   64'(desc_done), 64'd0);
        tick();
        check("t1_busy",  64'(seq_busy),     64'd0);
        check("t1_empty", 64'(exp_q.size()), 64'd0);
        check("t1_dd",    64'(dd_cnt),       64'd1);

        // Batch of three with stride 0x10
        exp_q.push_back(mk(12'h100, 12'h200, 12'h300, 12'h400, 8, 8, 16));
        exp_q.push_back(mk(12'h110, 12'h210, 12'h310, 12'h410, 8, 8, 16));
        exp_q.push_back(mk(12'h120, 12'h220, 12'h320, 12'h420, 8, 8, 16));
        push(mk(12'h100, 12'h200, 12'h300, 12'h400, 8, 8, 16), 3, 16);
        serve(3, 3);
        repeat (3) tick();
        check("t2_empty", 64'(exp_q.size()), 64'd0);
        check("t2_hs",    64'(hs_cnt),       64'd4);
        check("t2_dd",    64'(dd_cnt),       64'd2);

        // Capacity: one working descriptor plus DEPTH queued
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) exp_q.push_back(mk(16 + i, 32 + i, 48 + i, 64 + i, i, i + 1, i + 2));
            offer(mk(16 + i, 32 + i, 48 + i, 64 + i, i, i + 1, i + 2), 1, 0, acc);
            check("cap_accept", 64'(acc), 64'(i < 5));
        end
        check("cap_level", 64'(queue_level),         64'd4);
        check("cap_ready", 64'(bus.host_desc_ready), 64'd0);
        check("cap_hold",  64'(bus.cmd_valid),       64'd1);
        bus.cmd_ready = 1'b1;
        serve(5, 1);
        repeat (3) tick();
        check("cap_empty", 64'(exp_q.size()), 64'd0);
        check("cap_dd",    64'(dd_cnt),       64'd7);
        check("cap_busy",  64'(seq_busy),     64'd0);

        // Per-field address wrap
        exp_q.push_back(mk(12'h3F8, 12'h3F0, 12'h3FF, 12'h005, 1, 2, 3));
        exp_q.push_back(mk(12'h008, 12'h000, 12'h00F, 12'h015, 1, 2, 3));
        push(mk(12'h3F8, 12'h3F0, 12'h3FF, 12'h005, 1, 2, 3), 2, 16);
        serve(2, 0);
        repeat (3) tick();
        check("wrap_empty", 64'(exp_q.size()), 64'd0);
        check("wrap_dd",    64'(dd_cnt),       64'd8);

        // Zero batch and stray done while idle
        hs0 = hs_cnt;
        offer(mk(1, 2, 3, 4, 5, 6, 7), 0, 16, acc);
        check("bz_pulse", 64'(err_batch_zero), 64'd1);
        tick();
        check("bz_end",   64'(err_batch_zero), 64'd0);
        check("bz_level", 64'(queue_level),    64'd0);
        repeat (5) tick();
        check("bz_nocmd", 64'(hs_cnt),         64'(hs0));
        check("bz_cnt",   64'(ebz_cnt),        64'd1);
        pulse_done();
        check("stray_pulse", 64'(err_stray_done), 64'd1);
        tick();
        check("stray_end", 64'(err_stray_done), 64'd0);
        check("stray_cnt", 64'(esd_cnt),        64'd1);
        check("stray_dd",  64'(dd_cnt),         64'd8);

        // Reset while waiting for done with two queued
        exp_q.push_back(mk(12'h111, 12'h222, 12'h333, 12'h044, 4, 4, 4));
        push(mk(12'h111, 12'h222, 12'h333, 12'h044, 4, 4, 4), 2, 16);
        wait_hs();
        push(mk(1, 1, 1, 1, 1, 1, 1), 1, 0);
        push(mk(2, 2, 2, 2, 2, 2, 2), 1, 0);
        check("mid_level", 64'(queue_level), 64'd2);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 64'(bus.cmd_valid), 64'd0);
        check("mid_rst_level", 64'(queue_level),   64'd0);
        check("mid_rst_busy",  64'(seq_busy),      64'd0);
        rst = 1'b0;
        served = hs_cnt;
        hs0 = hs_cnt;
        tick();
        pulse_done();
        check("mid_stray", 64'(err_stray_done), 64'd1);
        repeat (10) tick();
        check("mid_nocmd", 64'(hs_cnt),         64'(hs0));
        check("mid_empty", 64'(exp_q.size()),   64'd0);
        check("mid_esd",   64'(esd_cnt),        64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tpu_cmd_sequencer.md
Name: tpu_cmd_sequencer

Overview:
Host-side command front end placed between the host command port and control_unit. It queues up to DEPTH host descriptors. Each descriptor expands into BATCH back-to-back 64-bit control_unit commands; every address field advances by a stride between commands. The block issues one command at a time and waits for control_unit done_irq before issuing the next. This lets the host submit batched GEMM tiles without polling each completion.

Parameters:
ADDR_WIDTH, 10, unified-buffer address width (4*ADDR_WIDTH+24 must equal 64)
DEPTH, 4, descriptor FIFO entries (power of 2, >=2)
BATCH_W, 8, width of per-descriptor repeat count

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
host_desc_valid  in  1  descriptor offer
host_desc_ready  out  1  descriptor accept (= FIFO not full)
host_desc_cmd  in  64  base command, packed MSB->LSB {addr_d,addr_c,addr_b,addr_a,len_n[8],len_k[8],len_m[8]}
host_desc_batch  in  BATCH_W  number of commands to issue
host_desc_stride  in  ADDR_WIDTH  increment added to all four addresses per repeat
cmd_valid  out  1  command to control_unit
cmd_ready  in  1  control_unit accept
cmd_data  out  64  command to control_unit, same packing
cu_done  in  1  control_unit done_irq, single-cycle pulse
queue_level  out  $clog2(DEPTH)+1  FIFO occupancy
seq_busy  out  1  working descriptor active or FIFO non-empty
desc_done  out  1  1-cycle pulse: last command of a descriptor completed
err_batch_zero  out  1  1-cycle pulse: descriptor with batch=0 dropped
err_stray_done  out  1  1-cycle pulse: cu_done outside WAIT_DONE

Behaviour:
- Reset: all outputs 0 except host_desc_ready=1. FIFO is emptied, FSM goes to IDLE, working registers are cleared. Reset mid-operation aborts the current descriptor; cmd_valid is low after the reset edge.
- Push: on host_desc_valid&&host_desc_ready. A batch=0 descriptor is not stored and raises err_batch_zero in the following cycle. Push and pop in the same cycle are legal; queue_level is unchanged.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE: if FIFO is non-empty, pop the head into the working registers (cur_cmd, remaining=batch, stride), then go to ISSUE.
- ISSUE: drive cmd_valid=1 and cmd_data=cur_cmd. Both hold stable until cmd_valid&&cmd_ready; then go to WAIT_DONE with cmd_valid=0 the next cycle.
- WAIT_DONE, on cu_done with remaining>1: each address field += stride (mod 2^ADDR_WIDTH, wraps, no carry between fields); len fields unchanged; remaining-=1; go to ISSUE.
- WAIT_DONE, on cu_done with remaining==1: pulse desc_done, go to IDLE.
- Latency: with an empty FIFO and the FSM in IDLE, a descriptor accepted at edge t gives cmd_valid=1 after edge t+2. cu_done at edge t gives the next cmd_valid after edge t+1 (same descriptor) or t+2 (next descriptor).
- cu_done in IDLE or ISSUE: ignored, pulse err_stray_done.
- Capacity: the working register holds one descriptor in addition to the FIFO. Total in flight is DEPTH+1.

Decomposition:
- tpu_cmd_pkg: command_t packed struct (addr_d, addr_c, addr_b, addr_a, len_n, len_k, len_m), the state enum, and the ADDR_WIDTH default. Shared with control_unit and the benches.
- Sub-module sync_fifo (parametrised WIDTH/DEPTH, synchronous rst, show-ahead read) holds {cmd, batch, stride}.

Test Plan:
- Batch=1, cmd A=0x100 B=0x200 C=0x300 D=0x400 K=8 N=8 M=16, cmd_ready=1 -> one cmd_data equal to the input. desc_done pulses one cycle after cu_done. seq_busy returns to 0.
- Batch=3, stride=0x10 -> three commands with A=0x100/0x110/0x120 and D=0x400/0x410/0x420. Each command issues only after the previous cu_done; exactly one desc_done.
- DEPTH=4, cmd_ready held 0, offer 7 descriptors -> 5 accepted (1 working + 4 queued), then host_desc_ready=0 and queue_level=4. Releasing cmd_ready drains them in FIFO order.
- Wrap: addr_a=0x3F8, stride=0x10, batch=2 -> second command addr_a=0x008; the other fields wrap independently.
- Batch=0 descriptor -> err_batch_zero pulse, queue_level unchanged, no cmd_valid. A cu_done pulse while idle -> err_stray_done pulse only.
- rst asserted in WAIT_DONE with 2 queued -> next cycle: cmd_valid=0, queue_level=0, seq_busy=0. A later cu_done gives err_stray_done and no command.
